// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types and widths for the data-side memory port.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam int c_addr_w = 16;
    localparam int c_data_w = 32;
    localparam int c_depth  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } dmp_state_t;

    typedef struct packed {
        logic [c_addr_w-1:0] addr;
        logic [c_data_w-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// Module   : store_fifo
// Brief    : Circular store buffer; DATA_MEM_FORWARD_EN adds a youngest-match
//            address search port.
// Revision : 1.0 - initial release
// ============================================================================
module store_fifo
    import data_mem_pkg::*;
#(
    parameter int DEPTH = c_depth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wb_entry_t              i_push_entry,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
`ifdef DATA_MEM_FORWARD_EN
    ,
    input  logic [c_addr_w-1:0]    i_lookup_addr,
    output logic                   o_hit,
    output logic [c_data_w-1:0]    o_hit_data
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    wb_entry_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);

`ifdef DATA_MEM_FORWARD_EN
    logic [c_ptr_w-1:0] w_idx;

    // Walk oldest to youngest so the last live match wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_ptr_w'(i);
            if ((c_cnt_w'(i) < r_count) && (r_mem[w_idx].addr == i_lookup_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_mem[w_idx].data;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_port
// Brief    : Datapath-to-memory port with buffered stores and a req/ack bus.
//            DATA_MEM_FORWARD_EN enables store-to-load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_port
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = c_depth,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              BufEmpty
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    dmp_state_t          r_state;
    dmp_state_t          w_next;
    logic [DATA_W-1:0]   r_rdata;
    wb_entry_t           w_push_entry;
    wb_entry_t           w_head;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_load;
    logic                w_push;
    logic                w_pop;
    logic                w_miss;
    logic                w_more;
    logic                w_rd_from_idle;
    logic                w_rd_after_write;

    // A simultaneous load and store is served as the store alone.
    assign w_load       = MemRead & ~MemWrite;
    assign w_push       = MemWrite & ~w_full;
    assign w_pop        = (r_state == WRITE) & MemAck;
    assign w_more       = (w_count != c_cnt_w'(1)) | w_push;
    assign w_push_entry = '{addr: Addr, data: WriteData};

`ifdef DATA_MEM_FORWARD_EN
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .i_lookup_addr (Addr),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data)
    );

    // Misses go straight to the bus; queued stores cannot alias them.
    assign w_miss           = w_load & ~w_hit;
    assign w_rd_from_idle   = w_miss;
    assign w_rd_after_write = w_miss;
    assign ReadData         = (r_state == RESP) ? r_rdata : w_hit_data;
`else
    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Loads wait until every earlier store has reached memory.
    assign w_miss           = w_load;
    assign w_rd_from_idle   = w_load & w_empty;
    assign w_rd_after_write = w_load & (w_count == c_cnt_w'(1));
    assign ReadData         = r_rdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == READ) && MemAck) r_rdata <= MemRData;
        end
    end

    always_comb begin
        w_next   = r_state;
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        case (r_state)
            IDLE: begin
                if (w_rd_from_idle)          w_next = READ;
                else if (!w_empty || w_push) w_next = WRITE;
            end
            WRITE: begin
                MemReq   = 1'b1;
                MemWe    = 1'b1;
                MemAddr  = w_head.addr;
                MemWData = w_head.data;
                if (MemAck) begin
                    if (w_rd_after_write) w_next = READ;
                    else if (w_more)      w_next = WRITE;
                    else                  w_next = IDLE;
                end
            end
            READ: begin
                MemReq  = 1'b1;
                MemAddr = Addr;
                if (MemAck) w_next = RESP;
            end
            RESP: begin
                w_next = (!w_empty || w_push) ? WRITE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign Stall    = MemWrite ? w_full : (w_miss && (r_state != RESP));
    assign BufEmpty = w_empty & ((r_state == IDLE) | (r_state == RESP));

    assert property (@(posedge clk) disable iff (reset) !(MemRead && MemWrite));

endmodule
`default_nettype wire

// File: doc/data_mem_port.md
# data_mem_port

Data-side memory port between the single-cycle datapath and the backing data RAM/peripheral bus. It accepts loads and stores from the datapath (address = `ALUResult`, data = `WriteData`) and buffers stores in a DEPTH-entry write FIFO. The FIFO drains to memory over a req/ack handshake. Loads are served by store-to-load forwarding or by a memory read, and `Stall` freezes the datapath (PC enable) while a request cannot complete this cycle.

## Interface
- `DEPTH`, 4: write-buffer entries; power of two, ≥2
- `ADDR_W`, 16: word-address width (word-addressed, matching PC increment of 1)
- `DATA_W`, 32: data width
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high
- `MemRead` in 1: load request this cycle
- `MemWrite` in 1: store request this cycle
- `Addr` in ADDR_W: load/store word address
- `WriteData` in DATA_W: store data
- `ReadData` out DATA_W: load result, valid when `MemRead`=1 and `Stall`=0
- `Stall` out 1: datapath must hold PC and all request inputs stable
- `MemReq` out 1: bus request
- `MemWe` out 1: 1 = write, 0 = read
- `MemAddr` out ADDR_W: bus address
- `MemWData` out DATA_W: bus write data
- `MemAck` in 1: bus completes the current request this cycle
- `MemRData` in DATA_W: read data, sampled when `MemAck`=1 and `MemWe`=0
- `BufEmpty` out 1: FIFO empty and no bus transaction in flight

## Operation
- FSM states: IDLE, WRITE (head store on bus), READ (load on bus), RESP (load data ready).
- Store accepted when `MemWrite`=1 and count<DEPTH: push {Addr, WriteData} at tail; `Stall`=0. With count==DEPTH: `Stall`=1 and no push. The push happens the cycle after a pop lowers the registered count.
- A push and a pop in the same cycle leave count unchanged. Pointers are log2(DEPTH) bits and wrap mod DEPTH. Count is log2(DEPTH)+1 bits.
- Drain: in IDLE with FIFO non-empty and no load pending → WRITE. `MemReq`=1, `MemWe`=1, `MemAddr`/`MemWData` from head, held stable until `MemAck`. On ack: pop. Go back to WRITE if entries remain, otherwise to IDLE.
- Load hit: with FORWARD_EN, an address match in the FIFO returns the youngest matching entry combinationally. `Stall`=0; no bus access.
- Load miss: `Stall`=1.
  - The load enters READ from IDLE, or from WRITE after the in-flight write acks.
  - READ takes priority over further draining.
  - READ drives `MemReq`=1, `MemWe`=0, `MemAddr`=Addr. On `MemAck`, `MemRData` is registered → RESP.
  - In RESP, `ReadData` = the registered value and `Stall`=0. Next state: IDLE, or WRITE if the FIFO is non-empty.
- `MemRead` and `MemWrite` both high is illegal. Treat it as a store only, and flag it with a simulation assertion.
- A transaction, once started, is never abandoned except by reset.

## Timing
- Store, not full: zero-stall; the earliest bus write is the cycle after the push.
- Load miss, minimum: cycle t `Stall`=1; t+1 READ, `MemReq`=1, ack at t+1; t+2 RESP, `Stall`=0, load retires at end of t+2.
- Each write costs 1 cycle plus the memory wait cycles. Back-to-back writes keep `MemReq` high, with the next head presented the cycle after the ack.
- Reset values: state IDLE, FIFO empty, `MemReq`=0, `MemWe`=0, `MemAddr`=0, `MemWData`=0, read register 0, `Stall`=0, `BufEmpty`=1.
- Reset mid-transaction: `MemReq` drops asynchronously and buffered stores are discarded.

## Configuration
- `DATA_MEM_FORWARD_EN` defined: FIFO address compare and youngest-match forwarding; misses bypass queued stores (a miss cannot alias them).
- `DATA_MEM_FORWARD_EN` undefined: no compare logic. Every load stalls until the FIFO is empty and no write is in flight, then performs READ. Loads are always ordered after all prior stores.

## Structure
- Package `data_mem_pkg`: state enum typedef `dmp_state_t`, struct `wb_entry_t` {addr, data}, and width constants.
- Sub-module `store_fifo`: circular buffer with push/pop, count, full/empty, and (under the macro) a youngest-match search port.

## Test plan
- Reset, then store A=0x0010 D=0x1234_5678 with ack latency 0 → `Stall`=0; the next cycle has `MemReq`=1, `MemWe`=1, `MemAddr`=0x0010; `BufEmpty`=1 after the ack.
- 5 stores with DEPTH=4 and `MemAck` held low → the 5th store sees `Stall`=1. Raise ack for 1 cycle → the 5th store is pushed the following cycle and count returns to 4.
- With forwarding: stores 0x20←0xAA then 0x20←0xBB, then a load of 0x20 with `MemAck` low → `ReadData`=0xBB, `Stall`=0, no read request.
- Load miss at 0x40 with 2 wait cycles and `MemRData`=0xCAFE → `Stall` high for 4 cycles, then `ReadData`=0xCAFE.
- Without the macro: 2 buffered stores, then a load → both writes complete before the READ request appears.
- `reset` asserted during WRITE → `MemReq`=0 immediately, FIFO empty, state IDLE.
